// File: rtl/neuron_tdm_scheduler.sv
// Time-multiplexes one Izhikevich update datapath across NUM_NEURONS neurons, in index order on each tick.
// Issue-to-issue is 2 cycles with zero-wait ack; dp_req holds until dp_ack; spike FIFO drops and flags when full.
module neuron_tdm_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2,
  parameter int DW          = 18,
  parameter int SPK_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             tick,
  input  logic             cur_we,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       cur_data,
  output logic             dp_req,
  output logic [DW-1:0]    dp_v,
  output logic [DW-1:0]    dp_u,
  output logic [DW-1:0]    dp_i,
  input  logic             dp_ack,
  input  logic [DW-1:0]    dp_v_nxt,
  input  logic [DW-1:0]    dp_u_nxt,
  input  logic             dp_spike,
  output logic             spk_valid,
  output logic [IDX_W-1:0] spk_idx,
  input  logic             spk_ready,
  output logic             busy,
  output logic             step_done,
  output logic             tick_miss,
  output logic             spk_ovf,
  input  logic             status_clr
);

  localparam int PW = $clog2(SPK_DEPTH);
  localparam logic [DW-1:0]    V_RST = DW'(18'h34CCD);
  localparam logic [DW-1:0]    U_RST = DW'(18'h3CCCD);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [PW:0]      FULL  = (PW + 1)'(SPK_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_inc;
  logic [DW-1:0]    v_mem   [NUM_NEURONS];
  logic [DW-1:0]    u_mem   [NUM_NEURONS];
  logic [7:0]       cur_mem [NUM_NEURONS];
  logic [DW-1:0]    cap_v;
  logic [DW-1:0]    cap_u;
  logic             cap_spike;

  logic [IDX_W-1:0] fifo_mem [SPK_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW:0]      cnt;
  logic [PW:0]      cnt_nxt;
  logic [IDX_W-1:0] head_nxt;
  logic             push;
  logic             push_ok;
  logic             pop;
  logic             drop;
  logic             tick_ign;

  assign idx_inc = idx + IDX_W'(1);

  // Input currents; a write lands next cycle and never disturbs operands already latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) cur_mem[n] <= '0;
    end else if (cur_we) begin
      cur_mem[cur_idx] <= cur_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      dp_req    <= 1'b0;
      dp_v      <= '0;
      dp_u      <= '0;
      dp_i      <= '0;
      cap_v     <= '0;
      cap_u     <= '0;
      cap_spike <= 1'b0;
      busy      <= 1'b0;
      step_done <= 1'b0;
      for (int n = 0; n < NUM_NEURONS; n++) begin
        v_mem[n] <= V_RST;
        u_mem[n] <= U_RST;
      end
    end else begin
      step_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && ena) begin
            idx    <= '0;
            dp_v   <= v_mem[0];
            dp_u   <= u_mem[0];
            dp_i   <= DW'({cur_mem[0], 10'b0});
            dp_req <= 1'b1;
            busy   <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (dp_ack) begin
            cap_v     <= dp_v_nxt;
            cap_u     <= dp_u_nxt;
            cap_spike <= dp_spike;
            dp_req    <= 1'b0;
            state     <= S_WB;
          end
        end
        S_WB: begin
          // cap_spike is consumed here so a paused WB pushes the event only once.
          v_mem[idx] <= cap_v;
          u_mem[idx] <= cap_u;
          cap_spike  <= 1'b0;
          if (idx == LAST) begin
            state <= S_DONE;
          end else if (ena) begin
            idx    <= idx_inc;
            dp_v   <= v_mem[idx_inc];
            dp_u   <= u_mem[idx_inc];
            dp_i   <= DW'({cur_mem[idx_inc], 10'b0});
            dp_req <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_DONE: begin
          step_done <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Spike FIFO with a registered head; a pop in the same cycle makes room for a push into a full FIFO.
  always_comb begin
    push       = (state == S_WB) && cap_spike;
    pop        = spk_valid && spk_ready;
    push_ok    = push && ((cnt != FULL) || pop);
    drop       = push && (cnt == FULL) && !pop;
    rd_ptr_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    cnt_nxt    = cnt + (PW + 1)'(push_ok) - (PW + 1)'(pop);
    head_nxt   = fifo_mem[rd_ptr_nxt];
    if (push_ok && (rd_ptr_nxt == wr_ptr)) head_nxt = idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      spk_valid <= 1'b0;
      spk_idx   <= '0;
      for (int n = 0; n < SPK_DEPTH; n++) fifo_mem[n] <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= idx;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      rd_ptr    <= rd_ptr_nxt;
      cnt       <= cnt_nxt;
      spk_valid <= (cnt_nxt != '0);
      spk_idx   <= head_nxt;
    end
  end

  assign tick_ign = tick && ((state != S_IDLE) || !ena);

  // Sticky status: a new set event beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_miss <= 1'b0;
      spk_ovf   <= 1'b0;
    end else begin
      if (tick_ign)        tick_miss <= 1'b1;
      else if (status_clr) tick_miss <= 1'b0;
      if (drop)            spk_ovf   <= 1'b1;
      else if (status_clr) spk_ovf   <= 1'b0;
    end
  end

endmodule
